// File: rtl/aes_spi_ctrl.sv
// aes_spi_ctrl: sequences one SPI-fed AES transaction.
// The controller receives a key and then a data block serially from the host.
// It starts the AES core, waits for the core's result, and then shifts that
// result back out to the host serially.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   cs           host chip select, active low; one bit moves per clk while low
//   sin          serial input from the host, MSB first
//   sout         serial output to the host, registered, MSB first
//   key_out      key to the AES core, held from one latch to the next
//   block_out    data block to the AES core, held from one latch to the next
//   aes_start    one-cycle start pulse to the AES core
//   aes_done     core result valid, honoured only while waiting for the core
//   aes_result   core output, captured on aes_done
//   ready        high only while idle
//   done         one-cycle pulse after the last result bit has been shifted out
//   err          one-cycle pulse when cs is released in the middle of a receive
module aes_spi_ctrl #(
    parameter int Nk       = 4,
    parameter int datasize = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                sin,
    output logic                sout,
    output logic [Nk*32-1:0]    key_out,
    output logic [datasize-1:0] block_out,
    output logic                aes_start,
    input  logic                aes_done,
    input  logic [datasize-1:0] aes_result,
    output logic                ready,
    output logic                done,
    output logic                err
);

    localparam int unsigned KEYSIZE = Nk * 32;
    localparam int unsigned RXW     = (KEYSIZE > datasize) ? KEYSIZE : datasize;
    localparam int unsigned CW      = $clog2(RXW) + 1;

    localparam logic [CW-1:0] KEY_LAST  = CW'(KEYSIZE - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(datasize - 1);
    localparam logic [CW-1:0] TX_LAST   = CW'(datasize);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_KEY  = 3'd1,
        RX_DATA = 3'd2,
        RUN     = 3'd3,
        TX      = 3'd4,
        FIN     = 3'd5
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    // The rx and tx registers leave out the bit that would be shifted away.
    // The incoming bit or the presented bit completes the word, so no register
    // bit goes unread.
    logic [RXW-2:0]        rx;
    logic [datasize-2:0]   tx;
    logic [RXW-1:0]        rx_nxt_c;

    // Receive word including the bit being sampled on this edge.
    assign rx_nxt_c = {rx, sin};

    // Transaction sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rx        <= '0;
            tx        <= '0;
            key_out   <= '0;
            block_out <= '0;
            sout      <= 1'b0;
            aes_start <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ready     <= 1'b1;
        end else begin
            aes_start <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    // The first bit of a frame is taken on the edge that leaves IDLE.
                    if (!cs) begin
                        rx    <= rx_nxt_c[RXW-2:0];
                        cnt   <= CW'(1);
                        state <= RX_KEY;
                        ready <= 1'b0;
                    end
                end
                RX_KEY: begin
                    if (cs) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        rx <= rx_nxt_c[RXW-2:0];
                        if (cnt == KEY_LAST) begin
                            key_out <= rx_nxt_c[KEYSIZE-1:0];
                            cnt     <= '0;
                            state   <= RX_DATA;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (cs) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        rx <= rx_nxt_c[RXW-2:0];
                        if (cnt == DATA_LAST) begin
                            block_out <= rx_nxt_c[datasize-1:0];
                            aes_start <= 1'b1;
                            cnt       <= '0;
                            state     <= RUN;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                RUN: begin
                    // A done that coincides with our own start pulse is stale; skip it.
                    if (aes_done && !aes_start) begin
                        tx    <= aes_result[datasize-2:0];
                        sout  <= aes_result[datasize-1];
                        cnt   <= CW'(1);
                        state <= TX;
                    end
                end
                TX: begin
                    // cnt counts the bits presented so far; cs high freezes everything.
                    if (!cs) begin
                        if (cnt == TX_LAST) begin
                            sout  <= 1'b0;
                            done  <= 1'b1;
                            cnt   <= '0;
                            state <= FIN;
                        end else begin
                            sout <= tx[datasize-2];
                            tx   <= {tx[datasize-3:0], 1'b0};
                            cnt  <= cnt + CW'(1);
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_spi_ctrl.sv
// Testbench for aes_spi_ctrl.
// The bench drives directed SPI frames and answers as a simple core model.
// Expected result bits go onto a scoreboard queue when the core model drives
// its result, and come off the queue as they appear on sout.
module tb_aes_spi_ctrl;

    logic         clk = 1'b0;
    logic         rst, cs, sin, sout;
    logic         aes_start, aes_done, ready, done, err;
    logic [127:0] key_out, block_out, aes_result;

    int tests = 0;
    int fails = 0;
    int n_start = 0;
    int n_done = 0;
    int n_err = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    aes_spi_ctrl #(.Nk(4), .datasize(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .sin        (sin),
        .sout       (sout),
        .key_out    (key_out),
        .block_out  (block_out),
        .aes_start  (aes_start),
        .aes_done   (aes_done),
        .aes_result (aes_result),
        .ready      (ready),
        .done       (done),
        .err        (err)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (aes_start) n_start++;
        if (done) n_done++;
        if (err) n_err++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [127:0] key, input logic [127:0] blk);
        for (int i = 127; i >= 0; i--) begin
            cs = 1'b0; sin = key[i]; tick();
        end
        for (int i = 127; i >= 0; i--) begin
            cs = 1'b0; sin = blk[i]; tick();
        end
        cs = 1'b1; sin = 1'b0;
    endtask

    // Called right after the last data edge: the start cycle.
    task automatic check_start(input logic [127:0] key, input logic [127:0] blk);
        @(negedge clk);
        chk("aes_start", 128'(aes_start), 128'(1));
        chk("key_out", key_out, key);
        chk("block_out", block_out, blk);
        chk("ready_busy", 128'(ready), 128'(0));
    endtask

    // Core model: aes_done for one cycle, `delay` cycles after the start cycle.
    task automatic core_reply(input logic [127:0] res, input int delay);
        repeat (delay) tick();
        aes_done = 1'b1;
        aes_result = res;
        for (int i = 127; i >= 0; i--) exp_q.push_back(res[i]);
        tick();
        aes_done = 1'b0;
        aes_result = '0;
    endtask

    // Clock the 128 result bits out, optionally pausing 5 cycles before bit pause_at.
    task automatic receive(input int pause_at);
        logic b;
        int d0;
        d0 = n_done;
        for (int i = 0; i < 128; i++) begin
            if (i == pause_at) begin
                cs = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    chk("tx_pause_sout", 128'(sout), 128'(exp_q[0]));
                    tick();
                end
            end
            cs = 1'b0;
            @(negedge clk);
            b = exp_q.pop_front();
            chk("tx_bit", 128'(sout), 128'(b));
            tick();
        end
        cs = 1'b1;
        @(negedge clk);
        chk("fin_done", 128'(done), 128'(1));
        chk("fin_sout", 128'(sout), 128'(0));
        chk("fin_ready", 128'(ready), 128'(0));
        tick();
        @(negedge clk);
        chk("post_done", 128'(done), 128'(0));
        chk("post_ready", 128'(ready), 128'(1));
        chk("done_count", 128'(n_done - d0), 128'(1));
        chk("queue_empty", 128'(exp_q.size()), 128'(0));
    endtask

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        int s0;
        rst = 1'b1; cs = 1'b1; sin = 1'b0; aes_done = 1'b0; aes_result = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_sout", 128'(sout), 128'(0));
        chk("rst_key", key_out, 128'(0));
        chk("rst_block", block_out, 128'(0));
        chk("rst_pulses", 128'({aes_start, done, err}), 128'(0));
        rst = 1'b0;
        tick();

        // Abort after 60 key bits.
        for (int i = 127; i >= 68; i--) begin
            cs = 1'b0; sin = K1[i]; tick();
        end
        cs = 1'b1;
        @(negedge clk);
        chk("err_before", 128'(err), 128'(0));
        tick();
        @(negedge clk);
        chk("err_pulse", 128'(err), 128'(1));
        chk("err_ready", 128'(ready), 128'(1));
        chk("err_key_kept", key_out, 128'(0));
        tick();
        @(negedge clk);
        chk("err_clear", 128'(err), 128'(0));
        chk("err_no_start", 128'(n_start), 128'(0));
        tick();

        // FIPS-197 retry frame.
        send_frame(K1, P1);
        check_start(K1, P1);
        core_reply(R1, 10);
        receive(-1);
        chk("fips_start_count", 128'(n_start), 128'(1));
        chk("err_count", 128'(n_err), 128'(1));

        // Pause in the middle of transmit.
        send_frame(128'hdeadbeef_01234567_89abcdef_fedcba98, 128'h55aa55aa_0f0f0f0f_f0f0f0f0_12345678);
        check_start(128'hdeadbeef_01234567_89abcdef_fedcba98, 128'h55aa55aa_0f0f0f0f_f0f0f0f0_12345678);
        core_reply(128'hc001d00d_a5a5a5a5_5a5a5a5a_80000001, 10);
        receive(37);

        // Two back-to-back frames.
        s0 = n_start;
        send_frame(128'h11111111_22222222_33333333_44444444, 128'h0);
        check_start(128'h11111111_22222222_33333333_44444444, 128'h0);
        core_reply(128'h0123456789abcdef0123456789abcdef, 10);
        receive(-1);
        send_frame(128'hffffffff_00000000_ffffffff_0000fffe, 128'hffffffffffffffffffffffffffffffff);
        check_start(128'hffffffff_00000000_ffffffff_0000fffe, 128'hffffffffffffffffffffffffffffffff);
        core_reply(128'hfedcba9876543210fedcba9876543210, 10);
        receive(-1);
        chk("b2b_start_count", 128'(n_start - s0), 128'(2));

        // aes_done held from the start cycle: only the following cycle's result counts.
        send_frame(K1, 128'h00000000_00000000_00000000_00000001);
        check_start(K1, 128'h00000000_00000000_00000000_00000001);
        aes_done = 1'b1;
        aes_result = 128'haaaaaaaa_aaaaaaaa_aaaaaaaa_aaaaaaaa;
        tick();
        @(negedge clk);
        chk("early_done_sout", 128'(sout), 128'(0));
        aes_result = 128'h3c3c3c3c_c3c3c3c3_00ff00ff_ff00ff00;
        for (int i = 127; i >= 0; i--) exp_q.push_back(aes_result[i]);
        tick();
        aes_done = 1'b0;
        aes_result = '0;
        receive(-1);

        // Reset while waiting for the core.
        s0 = n_done;
        send_frame(P1, K1);
        check_start(P1, K1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_run_ready", 128'(ready), 128'(1));
        chk("rst_run_key", key_out, 128'(0));
        chk("rst_run_block", block_out, 128'(0));
        repeat (4) tick();
        aes_done = 1'b1;
        aes_result = R1;
        tick();
        aes_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_run_sout", 128'(sout), 128'(0));
            chk("rst_run_idle", 128'(ready), 128'(1));
            tick();
        end
        chk("rst_run_no_done", 128'(n_done - s0), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
